// File: rtl/lcd_scanout_dbuf_if.sv
// PPU-side pixel ingress bundle for the double-buffered LCD scan-out.
// The PPU drives it (master); the scan-out block consumes it (slave).
interface lcd_scanout_dbuf_if #(
    parameter int DW = 15
);
    logic          pix_we;
    logic [DW-1:0] pix_data;
    logic          lcd_on;
    logic          lcd_vsync;

    modport master (
        output pix_we,
        output pix_data,
        output lcd_on,
        output lcd_vsync
    );

    modport slave (
        input pix_we,
        input pix_data,
        input lcd_on,
        input lcd_vsync
    );
endinterface

// File: rtl/lcd_scanout_dbuf.sv
// Tear-free LCD scan-out with a two-bank frame buffer.
// The PPU fills the write bank; a finished frame is handed to the reader only at
// the output frame boundary, so every displayed frame is one complete PPU frame.
// Output video timing is generated locally and advanced by ce_pix.
module lcd_scanout_dbuf #(
    parameter int            DW        = 15,
    parameter int            H         = 160,
    parameter int            V         = 144,
    parameter int            HFP       = 8,
    parameter int            HS        = 32,
    parameter int            HBP       = 24,
    parameter int            VFP       = 4,
    parameter int            VS        = 3,
    parameter int            VBP       = 16,
    parameter logic [DW-1:0] OFF_VALUE = DW'(15'h7FFF),
    parameter int            CNTW      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    lcd_scanout_dbuf_if.slave ppu,
    output logic              hs,
    output logic              vs,
    output logic              hblank,
    output logic              vblank,
    output logic              de,
    output logic [DW-1:0]     pix_out,
    output logic [CNTW-1:0]   frames_dropped,
    output logic [CNTW-1:0]   frames_repeated
);

    localparam int HTOT = H + HFP + HS + HBP;
    localparam int VTOT = V + VFP + VS + VBP;
    localparam int HV   = H * V;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);
    localparam int PW   = $clog2(HV);
    localparam int AW   = $clog2(2 * HV);

    // Output timing counters and the running start-of-line offset into a bank
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [AW-1:0] line_off;

    // Writer state and bank bookkeeping
    logic [PW-1:0] wr_ptr;
    logic          wbank;
    logic          rbank;
    logic          pending;
    logic          valid;
    logic          show_off;

    // Writer next-state decisions for this cycle
    logic [PW-1:0] wr_ptr_n;
    logic          pending_w;
    logic          drop_now;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    // Reader side
    logic          h_last;
    logic          v_last;
    logic          boundary;
    logic          h_vis;
    logic          v_vis;
    logic          hs_raw;
    logic          vs_raw;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] ram_q;

    // First pipeline stage, aligned with the RAM read data
    logic          hs1;
    logic          vs1;
    logic          hb1;
    logic          vb1;
    logic          off1;

    logic [DW-1:0] mem [0:2*HV-1];

    assign h_last   = (int'(h_cnt) == HTOT - 1);
    assign v_last   = (int'(v_cnt) == VTOT - 1);
    assign boundary = ce_pix & h_last & v_last;
    assign h_vis    = (int'(h_cnt) < H);
    assign v_vis    = (int'(v_cnt) < V);
    assign hs_raw   = (int'(h_cnt) >= H + HFP) && (int'(h_cnt) < H + HFP + HS);
    assign vs_raw   = (int'(v_cnt) >= V + VFP) && (int'(v_cnt) < V + VFP + VS);
    assign rd_en    = ce_pix & h_vis & v_vis;
    assign rd_addr  = (rbank ? AW'(HV) : '0) + line_off + AW'(h_cnt);
    assign wr_addr  = (wbank ? AW'(HV) : '0) + AW'(wr_ptr);

    // Writer decisions: restart on vsync or LCD off, otherwise advance through the
    // bank and flag completion; the first pixel after an unconsumed completion drops it
    always_comb begin
        wr_ptr_n  = wr_ptr;
        pending_w = pending;
        drop_now  = 1'b0;
        wr_en     = 1'b0;
        if (!ppu.lcd_on || ppu.lcd_vsync) begin
            wr_ptr_n = '0;
            if (!ppu.lcd_on) begin
                pending_w = 1'b0;
            end
        end else if (ppu.pix_we) begin
            wr_en = 1'b1;
            if (pending && wr_ptr == '0) begin
                pending_w = 1'b0;
                drop_now  = 1'b1;
            end
            if (int'(wr_ptr) == HV - 1) begin
                pending_w = 1'b1;
                wr_ptr_n  = '0;
            end else begin
                wr_ptr_n = wr_ptr + 1'b1;
            end
        end
    end

    // Frame buffer: one write port for the PPU, one registered read port for scan-out
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= ppu.pix_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    // Raster counters; line_off tracks v_cnt*H so no multiplier is needed
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            line_off <= '0;
        end else if (ce_pix) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt    <= '0;
                    line_off <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                    if (int'(v_cnt) < V - 1) begin
                        line_off <= line_off + AW'(H);
                    end
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Writer pointer, completion flag, bank swap at the frame boundary and statistics;
    // the boundary sees the writer's update of this cycle so a frame finishing exactly
    // at the boundary is shown, while one dropped at the boundary is not
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            wbank           <= 1'b0;
            rbank           <= 1'b1;
            pending         <= 1'b0;
            valid           <= 1'b0;
            show_off        <= 1'b1;
            frames_dropped  <= '0;
            frames_repeated <= '0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            pending <= pending_w;
            if (drop_now && frames_dropped != '1) begin
                frames_dropped <= frames_dropped + 1'b1;
            end
            if (boundary) begin
                show_off <= ~ppu.lcd_on;
                if (pending_w) begin
                    rbank   <= wbank;
                    wbank   <= ~wbank;
                    pending <= 1'b0;
                    valid   <= 1'b1;
                end else if (valid && frames_repeated != '1) begin
                    frames_repeated <= frames_repeated + 1'b1;
                end
            end
        end
    end

    // Two-stage output pipeline keeping syncs, blanks and pixel data mutually aligned
    always_ff @(posedge clk) begin
        if (reset) begin
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            hb1     <= 1'b1;
            vb1     <= 1'b1;
            off1    <= 1'b1;
            hs      <= 1'b0;
            vs      <= 1'b0;
            hblank  <= 1'b1;
            vblank  <= 1'b1;
            de      <= 1'b0;
            pix_out <= '0;
        end else if (ce_pix) begin
            hs1    <= hs_raw;
            vs1    <= vs_raw;
            hb1    <= ~h_vis;
            vb1    <= ~v_vis;
            off1   <= show_off | ~valid;
            hs     <= hs1;
            vs     <= vs1;
            hblank <= hb1;
            vblank <= vb1;
            de     <= ~hb1 & ~vb1;
            if (hb1 | vb1) begin
                pix_out <= '0;
            end else if (off1) begin
                pix_out <= OFF_VALUE;
            end else begin
                pix_out <= ram_q;
            end
        end
    end

endmodule
